// File: rtl/inst_fetch_buf_pkg.sv
// Shared core definitions for the instruction fetch buffer: bubble values
// presented to decode and the fetch handshake payload layout.
package inst_fetch_buf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int INT_W_DEF = 8;

  // Bubble values driven to decode whenever no entry is presented.
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [7:0]  INT_NONE   = 8'h00;

  // Handshake payload at the default core widths.
  typedef struct packed {
    logic [XLEN_DEF-1:0]  inst;
    logic [XLEN_DEF-1:0]  addr;
    logic [INT_W_DEF-1:0] int_flag;
  } fetch_pkt_t;

  // Fetch addresses are word aligned once stored.
  function automatic logic [XLEN_DEF-1:0] align_addr(input logic [XLEN_DEF-1:0] a);
    return {a[XLEN_DEF-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_buf_if.sv
// Fetch-side and decode-side handshake bundle of the instruction fetch buffer.
// Signal suffixes are from the buffer's point of view.
interface inst_fetch_buf_if #(
  parameter int XLEN  = 32,
  parameter int INT_W = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [XLEN-1:0]  inst_i;
  logic [XLEN-1:0]  inst_addr_i;
  logic [INT_W-1:0] interrupt_flag_i;

  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  inst_o;
  logic [XLEN-1:0]  inst_addr_o;
  logic [INT_W-1:0] interrupt_flag_o;

  // Fetch unit / decode side driving the buffer.
  modport master (
    output in_valid_i, inst_i, inst_addr_i, interrupt_flag_i, out_ready_i,
    input  in_ready_o, out_valid_o, inst_o, inst_addr_o, interrupt_flag_o
  );

  // The buffer itself.
  modport slave (
    input  in_valid_i, inst_i, inst_addr_i, interrupt_flag_i, out_ready_i,
    output in_ready_o, out_valid_o, inst_o, inst_addr_o, interrupt_flag_o
  );
endinterface

// File: rtl/inst_fetch_buf_fifo_ctrl.sv
// Pointer and occupancy tracking for a power-of-two deep FIFO. Pointers wrap
// naturally at PTR_W bits; flush returns everything to the empty state.
module fifo_ctrl #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointer/count: flush wins and drops any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: decouples fetch from decode with a small FIFO.
// Entries are presented to decode the cycle after they are pushed; decode
// sees a NOP bubble whenever the buffer is empty or held.
module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  parameter  int INT_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             hold_i,
  inst_fetch_buf_if.slave  bus,
  output logic [CNT_W-1:0] count_o
);

  // Same field layout as fetch_pkt_t, sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0]  inst;
    logic [XLEN-1:0]  addr;
    logic [INT_W-1:0] int_flag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty;
  logic             push, pop;
  logic             out_valid;

  assign bus.in_ready_o = !full && !flush_i;
  assign push           = bus.in_valid_i && bus.in_ready_o;
  assign out_valid      = !empty && !hold_i;
  // A flush drops the pop as well; pointers go back to zero regardless.
  assign pop            = out_valid && bus.out_ready_i && !flush_i;

  fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .flush_i  (flush_i),
    .push_i   (push),
    .pop_i    (pop),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count_o),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Write the incoming word into the slot at the write pointer, address aligned.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr] = '{inst:     bus.inst_i,
                        addr:     {bus.inst_addr_i[XLEN-1:2], 2'b00},
                        int_flag: bus.interrupt_flag_i};
    end
  end

  // Payload storage: validity lives in fifo_ctrl, so slots need no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Present the head entry, or a bubble when nothing is valid for decode.
  always_comb begin
    head = mem_q[rd_ptr];
    bus.out_valid_o      = out_valid;
    bus.inst_o           = XLEN'(INST_NOP);
    bus.inst_addr_o      = XLEN'(RESET_ADDR);
    bus.interrupt_flag_o = INT_W'(INT_NONE);
    if (out_valid) begin
      bus.inst_o           = head.inst;
      bus.inst_addr_o      = head.addr;
      bus.interrupt_flag_o = head.int_flag;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf with a queue scoreboard: stimulus pushes
// expected entries as it issues accepted writes, a negedge monitor pops and
// compares on every decode handshake and checks bubbles otherwise.
module tb_inst_fetch_buf;
  import inst_fetch_buf_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       hold_i = 1'b0;
  logic [2:0] count_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  fetch_pkt_t sb[$];

  inst_fetch_buf_if #(.XLEN(32), .INT_W(8)) bus ();

  inst_fetch_buf #(.XLEN(32), .DEPTH(4), .INT_W(8)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .hold_i  (hold_i),
    .bus     (bus),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic set_push(input logic [31:0] inst, input logic [31:0] addr,
                          input logic [7:0] flg, input bit acc);
    bus.in_valid_i       = 1'b1;
    bus.inst_i           = inst;
    bus.inst_addr_i      = addr;
    bus.interrupt_flag_i = flg;
    if (acc) sb.push_back('{inst: inst, addr: {addr[31:2], 2'b00}, int_flag: flg});
  endtask

  task automatic chk_bubble(input string nm);
    chk({nm, "_inst"}, bus.inst_o, 64'h13);
    chk({nm, "_addr"}, bus.inst_addr_o, 64'h0);
    chk({nm, "_flag"}, bus.interrupt_flag_o, 64'h0);
  endtask

  // Monitor: compare head against scoreboard on each pop, bubble otherwise.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (bus.out_valid_o) begin
        if (bus.out_ready_i && !flush_i) begin
          if (sb.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL pop_unexpected: got inst %0h expected no entry", bus.inst_o);
          end else begin
            fetch_pkt_t e;
            e = sb.pop_front();
            chk("pop_inst", bus.inst_o, 64'(e.inst));
            chk("pop_addr", bus.inst_addr_o, 64'(e.addr));
            chk("pop_flag", bus.interrupt_flag_o, 64'(e.int_flag));
          end
        end
      end else begin
        chk_bubble("mon_bubble");
      end
    end
  end

  initial begin
    bus.in_valid_i = 1'b0; bus.inst_i = '0; bus.inst_addr_i = '0;
    bus.interrupt_flag_i = '0; bus.out_ready_i = 1'b0;

    // Reset state
    #2;
    chk("rst_count", count_o, 0);
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_ready", bus.in_ready_o, 1);
    chk_bubble("rst_bubble");
    #10 rst_n_i = 1'b1;

    // Single push: one-cycle latency, address aligned
    tick(); set_push(32'h0000_0013, 32'h8000_0002, 8'h05, 1);
    settle(); chk("t1_cnt0", count_o, 0); chk("t1_val0", bus.out_valid_o, 0);
    tick(); bus.in_valid_i = 1'b0;
    settle(); chk("t1_val1", bus.out_valid_o, 1); chk("t1_addr", bus.inst_addr_o, 64'h8000_0000);
    chk("t1_cnt1", count_o, 1);
    tick(); bus.out_ready_i = 1'b1;
    tick(); bus.out_ready_i = 1'b0;
    settle(); chk("t1_cnt_end", count_o, 0);

    // Fill to DEPTH, fifth push refused even with a simultaneous pop
    for (int i = 0; i < 4; i++) begin
      tick(); set_push(32'hA000_0000 + 32'(i), 32'h1000 + 32'(4*i) + 32'(i), 8'(8'h10 + i), 1);
    end
    tick(); set_push(32'hBAD0_0005, 32'h2000, 8'hFF, 0); bus.out_ready_i = 1'b1;
    settle(); chk("t2_full_cnt", count_o, 4); chk("t2_full_rdy", bus.in_ready_o, 0);
    tick(); bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    settle(); chk("t2_cnt3", count_o, 3); chk("t2_rdy", bus.in_ready_o, 1);
    tick(); bus.out_ready_i = 1'b1;
    repeat (3) tick();
    bus.out_ready_i = 1'b0;
    settle(); chk("t2_cnt_end", count_o, 0); chk("t2_sb_empty", 64'(sb.size()), 0);

    // Hold on a full buffer: bubble, no pop; release resumes pops
    for (int i = 0; i < 4; i++) begin
      tick(); set_push(32'hC000_0000 + 32'(i), 32'h3003 + 32'(16*i), 8'(8'h20 + i), 1);
    end
    tick(); bus.in_valid_i = 1'b0; hold_i = 1'b1; bus.out_ready_i = 1'b1;
    settle(); chk("t3_hold_val", bus.out_valid_o, 0); chk_bubble("t3_hold"); chk("t3_hold_cnt", count_o, 4);
    tick();
    settle(); chk("t3_hold_cnt2", count_o, 4);
    tick(); hold_i = 1'b0;
    settle(); chk("t3_rel_val", bus.out_valid_o, 1);
    repeat (4) tick();
    bus.out_ready_i = 1'b0;
    settle(); chk("t3_cnt_end", count_o, 0); chk("t3_sb_empty", 64'(sb.size()), 0);

    // Flush with count 3 and a same-cycle push
    for (int i = 0; i < 3; i++) begin
      tick(); set_push(32'hD000_0000 + 32'(i), 32'h4000 + 32'(4*i), 8'(i), 1);
    end
    tick(); set_push(32'hDEAD_BEEF, 32'h5000, 8'h77, 0); flush_i = 1'b1;
    settle(); chk("t4_flush_rdy", bus.in_ready_o, 0); chk("t4_pre_cnt", count_o, 3);
    tick(); flush_i = 1'b0; bus.in_valid_i = 1'b0; sb.delete();
    settle(); chk("t4_cnt", count_o, 0); chk("t4_val", bus.out_valid_o, 0);
    tick(); set_push(32'hE000_0001, 32'h6001, 8'h42, 1);
    tick(); bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    tick(); bus.out_ready_i = 1'b0;
    settle(); chk("t4_cnt_end", count_o, 0);

    // Continuous push+pop for 10 cycles, pointers wrap several times
    for (int i = 0; i < 2; i++) begin
      tick(); set_push(32'hF000_0000 + 32'(i), 32'h7000 + 32'(4*i), 8'(8'h30 + i), 1);
    end
    for (int i = 0; i < 10; i++) begin
      tick(); set_push(32'hF100_0000 + 32'(i), 32'h8001 + 32'(4*i), 8'(8'h40 + i), 1);
      bus.out_ready_i = 1'b1;
      settle(); chk("t5_cnt_const", count_o, 2);
    end
    tick(); bus.in_valid_i = 1'b0;
    repeat (2) tick();
    bus.out_ready_i = 1'b0;
    settle(); chk("t5_cnt_end", count_o, 0); chk("t5_sb_empty", 64'(sb.size()), 0);

    // Asynchronous reset between edges with two entries held
    for (int i = 0; i < 2; i++) begin
      tick(); set_push(32'h9000_0000 + 32'(i), 32'h9000 + 32'(4*i), 8'(i), 1);
    end
    tick(); bus.in_valid_i = 1'b0;
    settle(); chk("t6_cnt2", count_o, 2);
    #2 rst_n_i = 1'b0;
    #1;
    chk("t6_rst_cnt", count_o, 0); chk("t6_rst_val", bus.out_valid_o, 0);
    chk("t6_rst_rdy", bus.in_ready_o, 1); chk_bubble("t6_rst");
    sb.delete();
    #1 rst_n_i = 1'b1;
    tick(); set_push(32'h1234_5678, 32'hABCD_0003, 8'h99, 1);
    tick(); bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    tick(); bus.out_ready_i = 1'b0;
    settle(); chk("t6_cnt_end", count_o, 0); chk("t6_sb_empty", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buf.md
INST_FETCH_BUF -- requirements
Module: inst_fetch_buf

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning instruction and address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning buffer entries; a power of two, at least 2.
REQ-003 SHALL have parameter INT_W, default 8, meaning interrupt flag width.
REQ-004 SHALL have port clk_i  input  1  meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n_i  input  1  meaning reset; asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  meaning discard all buffered entries (branch/trap redirect).
REQ-007 SHALL have port hold_i  input  1  meaning decode stall; freeze output side.
REQ-008 SHALL have port in_valid_i  input  1  meaning fetch data present.
REQ-009 SHALL have port in_ready_o  output  1  meaning buffer accepts fetch data.
REQ-010 SHALL have port inst_i  input  XLEN  meaning fetched instruction.
REQ-011 SHALL have port inst_addr_i  input  XLEN  meaning fetched instruction address.
REQ-012 SHALL have port interrupt_flag_i  input  INT_W  meaning peripheral interrupt flags sampled with instruction.
REQ-013 SHALL have port out_valid_o  output  1  meaning head entry presented to decode.
REQ-014 SHALL have port out_ready_i  input  1  meaning decode consumes head.
REQ-015 SHALL have ports inst_o, inst_addr_o, interrupt_flag_o  output  XLEN/XLEN/INT_W  meaning head entry fields.
REQ-016 SHALL have port count_o  output  clog2(DEPTH+1)  meaning occupied entries.

Function
REQ-017 Push SHALL occur when in_valid_i and in_ready_o are both high on a rising edge.
REQ-018 in_ready_o SHALL equal (count_o < DEPTH) and not flush_i; there is no push into a full buffer even with a simultaneous pop.
REQ-019 Stored address SHALL be inst_addr_i with bits [1:0] forced to 0; inst_i and interrupt_flag_i are stored unmodified.
REQ-020 Pop SHALL occur when out_valid_o and out_ready_i are both high.
REQ-021 out_valid_o SHALL be high only when count_o > 0 and hold_i is low.
REQ-022 When out_valid_o is low, outputs SHALL be INST_NOP, RESET_ADDR and INT_NONE (bubble).
REQ-023 Latency SHALL be one cycle: an entry pushed at edge N is presented from edge N onward, i.e. in the cycle after the push cycle.
REQ-024 Ordering SHALL be strict FIFO; read and write pointers wrap modulo DEPTH.
REQ-025 Simultaneous push and pop on a non-full buffer SHALL leave count_o unchanged.
REQ-026 When flush_i is high, the next edge SHALL empty the buffer (count 0, pointers equal) and SHALL drop any same-cycle push and pop.
REQ-027 flush_i SHALL take priority over hold_i; hold_i SHALL never block push.
REQ-028 Storage contents need not be cleared on flush; only validity is tracked.

Reset
REQ-029 While rst_n_i is low, count_o SHALL be 0, pointers 0, out_valid_o 0 and outputs at bubble values, asynchronously.
REQ-030 in_ready_o SHALL be 1 during and after reset unless flush_i is high.
REQ-031 Reset asserted mid-operation SHALL discard all entries without waiting for a clock edge.

Structure
REQ-032 INST_NOP, RESET_ADDR, INT_NONE and the handshake payload struct {inst, addr, int_flag} SHALL live in the shared core package.
REQ-033 Pointer and count logic SHALL be one sub-module, fifo_ctrl, parametrised by DEPTH; payload storage stays in inst_fetch_buf.

Verification
REQ-034 After reset, push 0x00000013 @ 0x80000002 -> next cycle out_valid_o=1, inst_addr_o=0x80000000, count_o=1.
REQ-035 Push 4 entries with out_ready_i=0 (DEPTH=4) -> count_o=4, in_ready_o=0; fifth push ignored; then pop all -> original order.
REQ-036 Full buffer, hold_i=1, out_ready_i=1 -> out_valid_o=0, bubble outputs, no pop; release hold -> pops resume.
REQ-037 count_o=3, assert flush_i with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0, pushed word absent.
REQ-038 Continuous push and pop for 10 cycles -> count_o constant, pointers wrap, no loss.
REQ-039 Drop rst_n_i between clock edges with count_o=2 -> out_valid_o=0 and count_o=0 immediately.
